// File: rtl/axis_bridge_pkg.sv
// Shared definitions for the AXI-Stream bridge buffering blocks.
//   DEF_BUS_WIDTH : default tdata width
//   clog2()       : pointer-width helper usable in constant expressions
//   entry_w()     : width of one stored FIFO entry (tdata, plus tlast when
//                   AXIS_READ_FIFO_TLAST_EN is defined)
package axis_bridge_pkg;

    localparam int DEF_BUS_WIDTH = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int entry_w(input int bus_w);
`ifdef AXIS_READ_FIFO_TLAST_EN
        return bus_w + 1;
`else
        return bus_w;
`endif
    endfunction

endpackage

// File: rtl/axis_read_fifo_if.sv
// Handshake/data bundle between an AXIS source, axis_read_fifo and the
// downstream consumer.
//   slave  : the FIFO's view (upstream tvalid/tdata and downstream ready in,
//            tready/valid/data/level/overflow out)
//   master : the environment's view (mirror of slave)
// With AXIS_READ_FIFO_TLAST_EN defined the bundle also carries i_tlast,
// o_last and o_packets.
interface axis_read_fifo_if
    import axis_bridge_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int DEPTH     = 4
);
    localparam int PTR_W = clog2(DEPTH);

    logic                 i_tvalid;
    logic                 o_tready;
    logic [BUS_WIDTH-1:0] i_data_bus;
    logic                 o_valid;
    logic                 i_ready;
    logic [BUS_WIDTH-1:0] o_data;
    logic [PTR_W:0]       o_level;
    logic                 o_overflow;
`ifdef AXIS_READ_FIFO_TLAST_EN
    logic                 i_tlast;
    logic                 o_last;
    logic [PTR_W:0]       o_packets;

    modport slave  (input  i_tvalid, i_data_bus, i_ready, i_tlast,
                    output o_tready, o_valid, o_data, o_level, o_overflow, o_last, o_packets);
    modport master (output i_tvalid, i_data_bus, i_ready, i_tlast,
                    input  o_tready, o_valid, o_data, o_level, o_overflow, o_last, o_packets);
`else
    modport slave  (input  i_tvalid, i_data_bus, i_ready,
                    output o_tready, o_valid, o_data, o_level, o_overflow);
    modport master (output i_tvalid, i_data_bus, i_ready,
                    input  o_tready, o_valid, o_data, o_level, o_overflow);
`endif

endinterface

// File: rtl/axis_fifo_mem.sv
// Simple dual-port register array for the FIFO storage.
//   i_clk                         : write clock
//   i_wr_en, i_wr_addr, i_wr_data : synchronous write port
//   i_rd_addr -> o_rd_data        : asynchronous read port
// Storage is not reset; contents are only observed after being written.
module axis_fifo_mem
    import axis_bridge_pkg::*;
#(
    parameter int WIDTH = DEF_BUS_WIDTH,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/axis_read_fifo.sv
// AXI-Stream reader with a DEPTH-entry first-word-fall-through buffer.
//   i_clk, i_areset : clock, asynchronous active-high reset
//   bus (slave)     : i_tvalid/o_tready/i_data_bus upstream,
//                     o_valid/i_ready/o_data downstream,
//                     o_level occupancy, o_overflow sticky overrun flag
// Optional: AXIS_READ_FIFO_TLAST_EN stores tlast with each beat and adds
// o_last (head tlast) and o_packets (buffered beats carrying tlast).
module axis_read_fifo
    import axis_bridge_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int DEPTH     = 4
) (
    input logic             i_clk,
    input logic             i_areset,
    axis_read_fifo_if.slave bus
);
    localparam int             PTR_W    = clog2(DEPTH);
    localparam int             ENT_W    = entry_w(BUS_WIDTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] LVL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       level, level_next;
    logic                 tready_q, ovf_q;
    logic [BUS_WIDTH-1:0] last_data;
    logic [ENT_W-1:0]     wr_ent, rd_ent;
    logic                 push, pop, not_empty;

    assign not_empty = (level != '0);
    assign push      = bus.i_tvalid & tready_q;
    assign pop       = not_empty & bus.i_ready;

    always_comb begin
        level_next = level;
        if (push && !pop)      level_next = level + LVL_ONE;
        else if (pop && !push) level_next = level - LVL_ONE;
    end

`ifdef AXIS_READ_FIFO_TLAST_EN
    assign wr_ent = {bus.i_tlast, bus.i_data_bus};
`else
    assign wr_ent = bus.i_data_bus;
`endif

    axis_fifo_mem #(.WIDTH(ENT_W), .DEPTH(DEPTH), .AW(PTR_W)) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (push),
        .i_wr_addr (wr_ptr),
        .i_wr_data (wr_ent),
        .i_rd_addr (rd_ptr),
        .o_rd_data (rd_ent)
    );

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            tready_q  <= 1'b0;
            ovf_q     <= 1'b0;
            last_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                last_data <= rd_ent[BUS_WIDTH-1:0];
            end
            level <= level_next;
            // Registered from the next occupancy, so i_ready never reaches
            // o_tready combinationally and a full FIFO never accepts.
            tready_q <= (level_next < FULL_LVL);
            if (bus.i_tvalid && !tready_q && level == FULL_LVL) ovf_q <= 1'b1;
        end
    end

    assign bus.o_tready   = tready_q;
    assign bus.o_valid    = not_empty;
    // Empty FIFO shows the last popped beat rather than stale storage.
    assign bus.o_data     = not_empty ? rd_ent[BUS_WIDTH-1:0] : last_data;
    assign bus.o_level    = level;
    assign bus.o_overflow = ovf_q;

`ifdef AXIS_READ_FIFO_TLAST_EN
    logic           head_last;
    logic [PTR_W:0] pkt_q;

    assign head_last = not_empty & rd_ent[ENT_W-1];

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            pkt_q <= '0;
        end else begin
            case ({push & bus.i_tlast, pop & head_last})
                2'b10:   pkt_q <= pkt_q + LVL_ONE;
                2'b01:   pkt_q <= pkt_q - LVL_ONE;
                default: pkt_q <= pkt_q;
            endcase
        end
    end

    assign bus.o_last    = head_last;
    assign bus.o_packets = pkt_q;
`endif

endmodule

// File: tb/tb_axis_read_fifo.sv
module tb_axis_read_fifo;
    import axis_bridge_pkg::*;

    localparam int BW = 16;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic t_last = 1'b0;

    always #5 clk = ~clk;

    axis_read_fifo_if #(.BUS_WIDTH(BW), .DEPTH(DP)) bus();

    axis_read_fifo #(.BUS_WIDTH(BW), .DEPTH(DP)) dut (
        .i_clk    (clk),
        .i_areset (rst),
        .bus      (bus)
    );

`ifdef AXIS_READ_FIFO_TLAST_EN
    assign bus.i_tlast = t_last;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: queue of {tlast, data} beats in arrival order.
    logic [BW:0]   q[$];
    bit            m_rdy;
    bit            m_ovf;
    logic [BW-1:0] m_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_rdy  = 1'b0;
        m_ovf  = 1'b0;
        m_last = '0;
    endtask

    function automatic int model_pkts();
        int n = 0;
        foreach (q[i]) if (q[i][BW]) n++;
        return n;
    endfunction

    task automatic check_out();
        logic [BW-1:0] exp_d;
        exp_d = (q.size() != 0) ? q[0][BW-1:0] : m_last;
        chk("tready",   bus.o_tready,   m_rdy);
        chk("valid",    bus.o_valid,    q.size() != 0);
        chk("data",     bus.o_data,     exp_d);
        chk("level",    bus.o_level,    q.size());
        chk("overflow", bus.o_overflow, m_ovf);
`ifdef AXIS_READ_FIFO_TLAST_EN
        chk("last",     bus.o_last,     (q.size() != 0) ? q[0][BW] : 1'b0);
        chk("packets",  bus.o_packets,  model_pkts());
`endif
    endtask

    // One clock: apply the FIFO rules to the inputs present at the edge,
    // then compare every output shortly after the edge.
    task automatic tick();
        bit          psh, pp;
        logic [BW:0] ent;
        @(posedge clk);
        if (!rst) begin
            psh = bus.i_tvalid && m_rdy;
            pp  = (q.size() != 0) && bus.i_ready;
            if (bus.i_tvalid && !m_rdy && q.size() == DP) m_ovf = 1'b1;
`ifdef AXIS_READ_FIFO_TLAST_EN
            ent = {t_last, bus.i_data_bus};
`else
            ent = {1'b0, bus.i_data_bus};
`endif
            if (pp) m_last = q.pop_front() & {1'b0, {BW{1'b1}}};
            if (psh) q.push_back(ent);
            m_rdy = (q.size() < DP);
        end
        #1;
        check_out();
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1;
        model_reset();
        #1;
        check_out();
        repeat (cyc) tick();
        #2 rst = 1'b0;
    endtask

    initial begin
        int            sent, cyc, max_lvl;
        logic [BW-1:0] exp_v;

        bus.i_tvalid   = 1'b0;
        bus.i_ready    = 1'b0;
        bus.i_data_bus = '0;
        model_reset();

        // Reset then idle
        do_reset(3);
        tick();
        chk("rdy_after_release", bus.o_tready, 1);

        // Fill to full, then offer a fifth beat while full
        for (int i = 1; i <= 4; i++) begin
            bus.i_tvalid   = 1'b1;
            bus.i_data_bus = BW'(i);
            tick();
            chk("fill_level", bus.o_level, i);
        end
        bus.i_data_bus = 16'h0005;
        tick();
        tick();
        chk("ovf_set",   bus.o_overflow, 1);
        chk("full_rdy0", bus.o_tready,   0);
        chk("no_store5", bus.o_level,    4);

        // Single pop reopens tready; held beat goes in on the next edge
        chk("head1", bus.o_data, 16'h0001);
        bus.i_ready = 1'b1;
        tick();
        chk("rdy_after_pop", bus.o_tready, 1);
        bus.i_ready = 1'b0;
        tick();
        chk("refill_level", bus.o_level, 4);
        bus.i_tvalid = 1'b0;
        bus.i_ready  = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            exp_v = BW'(i);
            chk("drain_order", bus.o_data, exp_v);
            tick();
        end
        chk("drain_empty", bus.o_valid, 0);
        chk("drain_hold",  bus.o_data,  16'h0005);

        // Streaming with pointer wrap
        bus.i_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.i_data_bus = BW'(16'h0100 + i);
            tick();
            chk("stream_level", bus.o_level, 1);
            chk("stream_data",  bus.o_data,  16'h0100 + i);
        end
        bus.i_tvalid = 1'b0;
        tick();
        chk("stream_done", bus.o_valid, 0);

        // Three beats with tlast on the 2nd, then asynchronous reset
        bus.i_ready  = 1'b0;
        bus.i_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_data_bus = BW'(16'h0200 + i);
            t_last = (i == 1);
            tick();
        end
        bus.i_tvalid = 1'b0;
        t_last = 1'b0;
        tick();
        chk("three_buffered", bus.o_level, 3);
`ifdef AXIS_READ_FIFO_TLAST_EN
        chk("pkts_one", bus.o_packets, 1);
`endif
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        chk("head_second", bus.o_data, 16'h0201);
`ifdef AXIS_READ_FIFO_TLAST_EN
        chk("head_last", bus.o_last, 1);
`endif
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", bus.o_valid, 0);
        chk("arst_level", bus.o_level, 0);
        chk("arst_ovf",   bus.o_overflow, 0);
`ifdef AXIS_READ_FIFO_TLAST_EN
        chk("arst_pkts",  bus.o_packets, 0);
        chk("arst_last",  bus.o_last, 0);
`endif
        repeat (2) tick();
        #2 rst = 1'b0;
        tick();

        // Random traffic; source only offers when the FIFO is ready
        sent    = 0;
        cyc     = 0;
        max_lvl = 0;
        while (sent < 1000 && cyc < 20000) begin
            bus.i_tvalid   = m_rdy && ($urandom_range(1) == 1);
            bus.i_ready    = ($urandom_range(1) == 1);
            bus.i_data_bus = BW'($urandom);
            t_last         = ($urandom_range(3) == 0);
            if (bus.i_tvalid) sent++;
            tick();
            cyc++;
            if (int'(bus.o_level) > max_lvl) max_lvl = int'(bus.o_level);
        end
        chk("rand_sent",    sent, 1000);
        chk("rand_lvl_max", max_lvl <= DP, 1);
        chk("rand_no_ovf",  bus.o_overflow, 0);
        bus.i_tvalid = 1'b0;
        bus.i_ready  = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("rand_drained", bus.o_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_read_fifo.md
Name:
axis_read_fifo

Overview:
Parametrised successor to the single-transfer AXI-Stream reader. Accepts a stream on a slave port at full throughput (one beat per cycle) and buffers beats in a DEPTH-entry FIFO. Presents them on a downstream valid/ready interface with first-word-fall-through. Sits between an upstream AXIS master (FINN/Galapagos bridge datapath) and a consumer that may stall.

Parameters:
BUS_WIDTH, 16, data bus width in bits (>=1)
DEPTH, 4, FIFO entries; power of two, >=2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
i_clk  input  1  clock; all logic on rising edge
i_areset  input  1  asynchronous reset, active-high
i_tvalid  input  1  upstream beat valid
o_tready  output  1  upstream ready (registered)
i_data_bus  input  BUS_WIDTH  upstream tdata
o_valid  output  1  downstream data valid
i_ready  input  1  downstream consumer ready
o_data  output  BUS_WIDTH  head-of-FIFO data
o_level  output  PTR_W+1  current occupancy, 0..DEPTH
o_overflow  output  1  sticky: beat offered while buffer full

Behaviour:
- Reset (async assert, sync release): o_tready=0, o_valid=0, o_data=0, o_level=0, o_overflow=0; read/write pointers=0. Storage contents don't care. Asserting reset mid-transfer flushes all buffered beats with no partial output.
- First rising edge after reset release: o_tready goes 1 (DEPTH>=2 so empty is never full).
- Push = i_tvalid & o_tready at a clock edge. Write i_data_bus at wr_ptr; wr_ptr += 1 (mod DEPTH, natural wrap).
- Pop = o_valid & i_ready at a clock edge. rd_ptr += 1 (mod DEPTH).
- Level: level_next = level + push - pop. Simultaneous push and pop leaves level unchanged.
- o_tready registered: o_tready <= (level_next < DEPTH). No combinational path from i_ready to o_tready. The FIFO never accepts a beat when full.
- o_valid = (level != 0). o_data = mem[rd_ptr]. Latency: a beat pushed at edge N is visible on o_data with o_valid=1 after edge N, i.e. one cycle.
- Empty: o_valid=0 and o_data holds the last popped value, or 0 after reset. Pop is impossible, so i_ready is ignored.
- Full (level==DEPTH): o_tready=0. A pop at edge N raises o_tready after edge N. With i_tvalid held, the next push occurs at edge N+1.
- Sustained throughput: with i_ready=1 and i_tvalid=1 continuously, one beat per cycle after the first, and level stays at 1.
- Data ordering strictly FIFO. Beats are never duplicated or dropped while o_tready=1.
- o_overflow: set when i_tvalid=1 and o_tready=0 while level==DEPTH. Cleared only by reset.
- i_data_bus may change freely while o_tready=0. Sampled only on push.

Optional Feature:
Macro AXIS_READ_FIFO_TLAST_EN.
- Defined: adds ports i_tlast (input, 1) and o_last (output, 1). tlast is stored alongside data in each entry and o_last = tlast of the head entry, 0 when empty or in reset. Also adds o_packets (output, PTR_W+1): count of buffered beats with tlast=1, updated with push/pop.
- Not defined: ports absent, storage is BUS_WIDTH wide, and behaviour is otherwise identical.

Decomposition:
- Package axis_bridge_pkg: function clog2 helper, localparam for default BUS_WIDTH, and the per-entry width rule (BUS_WIDTH or BUS_WIDTH+1 with tlast).
- One sub-module, axis_fifo_mem: simple dual-port register array (write port: en, addr, data; asynchronous read: addr -> data), no reset on storage.
- Pointer, level and handshake logic stay in axis_read_fifo.

Test Plan:
- Reset then idle: assert i_areset for 3 cycles, release -> o_tready=0 in reset and 1 one cycle after release; o_valid=0, o_level=0, o_overflow=0.
- Fill to full, DEPTH=4: i_ready=0, push 0x0001..0x0004 on consecutive cycles -> o_level steps 1,2,3,4; o_tready=0 after 4th push; fifth beat 0x0005 held -> o_overflow=1 and 0x0005 not stored.
- Drain and refill: from full, i_ready=1 one cycle -> o_data=0x0001 popped, o_tready=1 next cycle, held 0x0005 accepted; then drain all -> order 0x0002,0x0003,0x0004,0x0005 and o_valid=0 after the last.
- Streaming with wrap: i_tvalid=i_ready=1 for 20 beats 0x0100..0x0113 -> outputs in order, each one cycle after acceptance, o_level constant 1, pointers wrap 5 times.
- Random backpressure: 1000 beats, random i_tvalid/i_ready at 50% -> scoreboard matches exactly, o_level never exceeds 4, no overflow while source obeys o_tready.
- Mid-operation reset, plus tlast when AXIS_READ_FIFO_TLAST_EN: buffer 3 beats with tlast on the 2nd, check o_packets=1 and o_last=1 when the 2nd reaches head; assert i_areset asynchronously (not clock-aligned) -> o_valid, o_level, o_packets, o_last drop to 0 immediately.
